// File: rtl/rf_ctx_engine_pkg.sv
// -----------------------------------------------------------------------------
// rf_ctx_engine_pkg
//   Shared types and constants for the register-file context save/restore
//   engine.
//   - state_e   : FSM state encoding (also exported on the debug port)
//   - NUM_REGS  : number of architectural registers in the register file
//   - REG_IDX_W : register index width
//   - ZERO_REG  : index of the hardwired-zero register (never transferred)
// -----------------------------------------------------------------------------
package rf_ctx_engine_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_RD  = 3'd1,
    ST_SAVE_REQ = 3'd2,
    ST_RST_REQ  = 3'd3,
    ST_RST_WR   = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/rf_ctx_engine.sv
// -----------------------------------------------------------------------------
// rf_ctx_engine
//   Context save/restore engine. Acts as initiator on the register-file port
//   and on a word-addressed memory port.
//   SAVE    : reads r1..r15 and writes them to base+0 .. base+14.
//   RESTORE : reads base+0 .. base+14 and writes them into r1..r15.
//   r0 is hardwired zero and is never transferred.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   start_save/start_restore single-cycle requests, sampled only in IDLE
//   base_addr                memory base address, latched at start
//   busy / done              busy while not IDLE; done pulses in DONE
//   rf_raddr / rf_rdata      RF read port (combinational read in the RF)
//   rf_waddr/rf_wen/rf_wdata RF write port
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until ack
//   mem_ack / mem_rdata      one-cycle ack, read data valid with the ack
//   dbg_state_o              current FSM state
//
// Memory handshake: mem_req rises with mem_we/mem_addr/mem_wdata already
// valid; all four stay constant until the cycle in which mem_ack=1 is
// sampled, after which mem_req drops for at least one cycle. mem_ack is
// ignored whenever mem_req=0.
// -----------------------------------------------------------------------------
module rf_ctx_engine
  import rf_ctx_engine_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_save,
  input  logic                 start_restore,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic                 rf_wen,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output state_e               dbg_state_o
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

  state_e                 state_q,     state_d;
  logic [REG_IDX_W-1:0]   idx_q,       idx_d;
  logic [ADDR_W-1:0]      base_q,      base_d;
  logic                   mem_req_q,   mem_req_d;
  logic                   mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]      rf_wdata_q,  rf_wdata_d;
  logic [REG_IDX_W-1:0]   rf_waddr_q,  rf_waddr_d;

  logic ack_seen;

  // Word address of register idx: base + (idx - FIRST_REG), wrapping
  // modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0]    base,
    input logic [REG_IDX_W-1:0] idx
  );
    return base + ADDR_W'(idx) - ADDR_W'(FIRST_REG);
  endfunction

  // Only an ack that arrives while a request is outstanding counts.
  assign ack_seen = mem_ack & mem_req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= FIRST_IDX;
      base_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_wdata_q  <= '0;
      rf_waddr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_waddr_q  <= rf_waddr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_wdata_d  = rf_wdata_q;
    rf_waddr_d  = rf_waddr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_save) begin
          base_d  = base_addr;
          idx_d   = FIRST_IDX;
          state_d = ST_SAVE_RD;
        end else if (start_restore) begin
          // The first read request is issued on entry so RST_REQ presents
          // a valid request in its very first cycle.
          base_d     = base_addr;
          idx_d      = FIRST_IDX;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = base_addr;
          state_d    = ST_RST_REQ;
        end
      end

      ST_SAVE_RD: begin
        mem_wdata_d = rf_rdata;
        mem_addr_d  = word_addr(base_q, idx_q);
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        state_d     = ST_SAVE_REQ;
      end

      ST_SAVE_REQ: begin
        if (ack_seen) begin
          mem_req_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + REG_IDX_W'(1);
            state_d = ST_SAVE_RD;
          end
        end
      end

      ST_RST_REQ: begin
        if (ack_seen) begin
          rf_wdata_d = mem_rdata;
          rf_waddr_d = idx_q;
          mem_req_d  = 1'b0;
          state_d    = ST_RST_WR;
        end
      end

      ST_RST_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d      = idx_q + REG_IDX_W'(1);
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = word_addr(base_q, idx_q + REG_IDX_W'(1));
          state_d    = ST_RST_REQ;
        end
      end

      ST_DONE: begin
        idx_d   = FIRST_IDX;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The RF read port only addresses a real register while SAVE_RD needs it;
  // elsewhere it is parked on the zero register.
  assign rf_raddr    = (state_q == ST_SAVE_RD) ? idx_q : ZERO_REG;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign rf_wen      = (state_q == ST_RST_WR);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rf_ctx_engine.sv
// -----------------------------------------------------------------------------
// tb_rf_ctx_engine
//   Bench for rf_ctx_engine: register-file and memory models, a memory
//   responder with programmable ack delay, a scoreboard fed by the reference
//   model and drained by a monitor, directed and randomized operations.
// -----------------------------------------------------------------------------
module tb_rf_ctx_engine;
  import rf_ctx_engine_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start_save = 1'b0;
  logic        start_restore = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic        busy, done;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_rdata, rf_wdata;
  logic        rf_wen;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  state_e      dbg_state;

  rf_ctx_engine dut (
    .clk(clk), .rst(rst),
    .start_save(start_save), .start_restore(start_restore),
    .base_addr(base_addr), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- models ----------------
  logic [15:0] rf [16];
  logic [15:0] mem [65536];
  logic [15:0] rf_snap [16];

  assign rf_rdata = rf[rf_raddr];

  initial forever begin
    @(posedge clk);
    if (rst && rf_wen) rf[rf_waddr] = rf_wdata;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_mem_q [$];  // {we, addr, wdata}
  logic [19:0] exp_rf_q  [$];  // {waddr, wdata}
  int total_cnt = 0;
  int bad_cnt   = 0;
  int done_cnt  = 0;
  int stab_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          ack_delay = 0;
  bit          spur_en   = 1'b0;
  int          wcnt      = 0;
  bit          held      = 1'b0;
  logic [32:0] held_val;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      mem_ack = 1'b0;
      wcnt    = 0;
      held    = 1'b0;
    end else if (mem_req) begin
      if (held) begin
        if ({mem_we, mem_addr, mem_wdata} !== held_val) stab_err++;
      end else begin
        held     = 1'b1;
        held_val = {mem_we, mem_addr, mem_wdata};
      end
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
        wcnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      held      = 1'b0;
      wcnt      = 0;
      mem_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (mem_req && mem_ack) begin
        if (exp_mem_q.size() == 0) begin
          check("mem_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_mem_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(e[32]));
          check("mem_addr", 32'(mem_addr), 32'(e[31:16]));
          if (e[32]) check("mem_wdata", 32'(mem_wdata), 32'(e[15:0]));
        end
      end
      if (rf_wen) begin
        check("rf_waddr_nonzero", 32'(rf_waddr != 4'd0), 32'd1);
        if (exp_rf_q.size() == 0) begin
          check("rf_unexpected", 32'(rf_waddr), 32'hFFFF_FFFF);
        end else begin
          logic [19:0] r;
          r = exp_rf_q.pop_front();
          check("rf_waddr", 32'(rf_waddr), 32'(r[19:16]));
          check("rf_wdata", 32'(rf_wdata), 32'(r[15:0]));
        end
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- reference model ----------------
  // A SAVE moves r1..r15 to base..base+14; a RESTORE moves base..base+14
  // into r1..r15. Addresses wrap at 16 bits.
  task automatic model_save(input logic [15:0] base);
    for (int k = 0; k < 15; k++) begin
      logic [15:0] a;
      a = base + 16'(k);
      exp_mem_q.push_back({1'b1, a, rf[k+1]});
    end
  endtask

  task automatic model_restore(input logic [15:0] base);
    for (int k = 0; k < 15; k++) begin
      logic [15:0] a;
      a = base + 16'(k);
      exp_mem_q.push_back({1'b0, a, 16'h0});
      exp_rf_q.push_back({4'(k + 1), mem[a]});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input bit do_save, input bit do_restore,
                        input logic [15:0] base, input int delay, input bit inject);
    int cycles;
    int nbusy;
    int d0;
    if (do_save) model_save(base);
    else         model_restore(base);
    ack_delay = delay;
    d0 = done_cnt;
    stab_err = 0;
    @(negedge clk);
    start_save    = do_save;
    start_restore = do_restore;
    base_addr     = base;
    @(negedge clk);
    start_save    = 1'b0;
    start_restore = 1'b0;
    base_addr     = 16'($urandom);
    cycles = 1;
    nbusy  = 0;
    while (!done && cycles < 3000) begin
      if (!busy) nbusy++;
      if (inject && cycles == 7) begin
        start_save    = 1'b1;
        start_restore = 1'b1;
      end else begin
        start_save    = 1'b0;
        start_restore = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start_save    = 1'b0;
    start_restore = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("busy_while_running", 32'(nbusy), 32'd0);
    if (delay == 0) check("latency", 32'(cycles), 32'd31);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_single_pulse", 32'(done_cnt - d0), 32'd1);
    check("mem_stable", 32'(stab_err), 32'd0);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
    check("rf_queue_drained", 32'(exp_rf_q.size()), 32'd0);
    exp_mem_q.delete();
    exp_rf_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_rf_wen"}, 32'(rf_wen), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_rf_wdata"}, 32'(rf_wdata), 32'd0);
    check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    check({tag, "_rf_raddr"}, 32'(rf_raddr), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] b;
    int d0, n, cyc;

    for (int i = 0; i < 16; i++) rf[i] = (i == 0) ? 16'h0 : 16'h1000 + 16'(i);

    // Reset state
    #1;
    check_outputs_zero("reset");
    #13;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // SAVE, zero-wait
    run_op(1'b1, 1'b0, 16'h0200, 0, 1'b0);
    for (int k = 0; k < 15; k += 7)
      check("save_mem_content", 32'(mem[16'h0200 + 16'(k)]), 32'h1001 + 32'(k));

    // RESTORE, zero-wait
    for (int k = 0; k < 15; k++) mem[16'h0300 + 16'(k)] = 16'hA000 + 16'(k);
    run_op(1'b0, 1'b1, 16'h0300, 0, 1'b0);
    check("restore_r1", 32'(rf[1]), 32'hA000);
    check("restore_r15", 32'(rf[15]), 32'hA00E);
    check("r0_untouched", 32'(rf[0]), 32'h0);

    // SAVE with 3 wait cycles per word
    for (int i = 1; i < 16; i++) rf[i] = 16'($urandom);
    run_op(1'b1, 1'b0, 16'h1234, 3, 1'b0);

    // Both starts high, start pulse while busy, spurious acks
    spur_en = 1'b1;
    run_op(1'b1, 1'b1, 16'h0500, 1, 1'b1);
    spur_en = 1'b0;

    // Reset in the middle of a RESTORE after 5 words
    b = 16'h0800;
    for (int k = 0; k < 15; k++) mem[b + 16'(k)] = 16'hC000 + 16'($urandom_range(0, 4095));
    for (int i = 0; i < 16; i++) rf_snap[i] = rf[i];
    model_restore(b);
    d0 = done_cnt;
    ack_delay = 0;
    @(negedge clk);
    start_restore = 1'b1;
    base_addr     = b;
    @(negedge clk);
    start_restore = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 1000) begin
      if (rf_wen) n++;
      if (n < 5) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("abort_reached_5_words", 32'(n), 32'd5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_mem_q.delete();
    exp_rf_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < 6; i++)
      check("abort_written_reg", 32'(rf[i]), 32'(mem[b + 16'(i - 1)]));
    for (int i = 6; i < 16; i++)
      check("abort_untouched_reg", 32'(rf[i]), 32'(rf_snap[i]));
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(1'b0, 1'b1, b, 0, 1'b0);
    check("restore_after_abort_r15", 32'(rf[15]), 32'(mem[b + 16'd14]));

    // Address wrap
    for (int i = 1; i < 16; i++) rf[i] = 16'($urandom);
    run_op(1'b1, 1'b0, 16'hFFFA, 0, 1'b0);
    check("wrap_ffff", 32'(mem[16'hFFFF]), 32'(rf[6]));
    check("wrap_0000", 32'(mem[16'h0000]), 32'(rf[7]));
    check("wrap_0008", 32'(mem[16'h0008]), 32'(rf[15]));

    // Randomized operations
    for (int t = 0; t < 8; t++) begin
      bit s;
      int dl;
      s  = 1'($urandom_range(0, 1));
      b  = 16'($urandom);
      dl = $urandom_range(0, 3);
      if (s) begin
        for (int i = 1; i < 16; i++) rf[i] = 16'($urandom);
      end else begin
        for (int k = 0; k < 15; k++) mem[b + 16'(k)] = 16'($urandom);
      end
      spur_en = 1'($urandom_range(0, 1));
      run_op(s, !s, b, dl, 1'($urandom_range(0, 1)));
    end
    spur_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/rf_ctx_engine.md
Name: rf_ctx_engine

Overview:
- Context save/restore engine acting as the initiator on the 16x16 register-file port. It drives read address, write address, write enable and write data.
- SAVE: streams r1..r15 out to a word-addressed memory port.
- RESTORE: reads 15 words back from memory and writes them into r1..r15. r0 is hardwired zero and is never transferred.
- Sits between the core control unit (which stalls the pipeline while busy=1) and the data-memory arbiter.

Parameters:
- DATA_W, 16, register and memory word width
- ADDR_W, 16, memory address width
- FIRST_REG, 1, first register index transferred
- LAST_REG, 15, last register index transferred

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- start_save  in  1  single-cycle request to begin SAVE; sampled only in IDLE
- start_restore  in  1  single-cycle request to begin RESTORE; sampled only in IDLE
- base_addr  in  ADDR_W  memory base address; latched at start
- busy  out  1  high from the cycle after start until DONE exits
- done  out  1  one-cycle pulse on completion
- rf_raddr  out  4  RF read address (combinational read in RF)
- rf_rdata  in  DATA_W  RF read data for rf_raddr
- rf_waddr  out  4  RF write address
- rf_wen  out  1  RF write enable
- rf_wdata  out  DATA_W  RF write data
- mem_req  out  1  memory request; held until acknowledged
- mem_we  out  1  1 = write (SAVE), 0 = read (RESTORE); stable while mem_req=1
- mem_addr  out  ADDR_W  word address; stable while mem_req=1
- mem_wdata  out  DATA_W  write data; stable while mem_req=1
- mem_ack  in  1  one-cycle acknowledge; valid only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, idx=FIRST_REG. busy, done, mem_req, mem_we, rf_wen all 0. mem_addr, mem_wdata, rf_wdata, rf_waddr, rf_raddr all 0.
- Reset mid-operation aborts immediately. No further RF writes occur. No partial-word guarantee is made to memory.
- States: IDLE, SAVE_RD, SAVE_REQ, RST_REQ, RST_WR, DONE.
- IDLE:
  - start_save=1 -> latch base, idx=FIRST_REG, go to SAVE_RD.
  - start_restore=1 (and start_save=0) -> latch base, idx=FIRST_REG, go to RST_REQ.
  - If both are high, SAVE wins.
  - Starts outside IDLE are ignored.
- SAVE_RD:
  - rf_raddr=idx.
  - Register rf_rdata into mem_wdata, and base+(idx-FIRST_REG) into mem_addr (modulo 2^ADDR_W).
  - Set mem_req=1, mem_we=1; go to SAVE_REQ.
- SAVE_REQ:
  - Hold mem_req until a cycle with mem_ack=1.
  - On ack: if idx==LAST_REG go to DONE with mem_req=0. Otherwise idx+1, mem_req=0, go to SAVE_RD.
  - Cost is 2 cycles per word with zero-wait ack.
- RST_REQ:
  - mem_req=1, mem_we=0, mem_addr=base+(idx-FIRST_REG).
  - On ack: capture mem_rdata into rf_wdata, rf_waddr=idx, drop mem_req, go to RST_WR.
- RST_WR:
  - rf_wen=1 for exactly this one cycle.
  - If idx==LAST_REG go to DONE. Otherwise idx+1, go to RST_REQ.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- rf_wen is never asserted outside RST_WR. rf_waddr is never 0.
- busy=1 in every non-IDLE, non-reset cycle, including DONE.
- Zero-wait total latency, counted from the start-sample edge to the done pulse: 30 cycles + 1 DONE cycle, for both SAVE and RESTORE.
- mem_ack while mem_req=0 is ignored.
- Address arithmetic wraps: base=16'hFFFA gives addresses FFFA..FFFF, then 0000..0008.

Decomposition:
- Shared package:
  - state enum: IDLE, SAVE_RD, SAVE_REQ, RST_REQ, RST_WR, DONE
  - NUM_REGS=16
  - REG_IDX_W=4
  - ZERO_REG=4'd0
- No sub-module. A single FSM with an index counter and datapath registers is enough.

Test Plan:
- Preload r1..r15 = 16'h1000+i; start_save, base=16'h0200, zero-wait ack -> 15 writes, addr 0x0200..0x020E, data 0x1001..0x100F; done pulses exactly once; r0 never read.
- Memory words 0x0300..0x030E = 16'hA000+k; start_restore, base=0x0300 -> rf_wen pulses 15 times, waddr 1..15, wdata 0xA000..0xA00E; no write to r0.
- SAVE with ack delayed 3 cycles per word -> mem_addr/mem_wdata/mem_we stable while mem_req=1; done after 15 acks.
- start_save and start_restore both high in IDLE -> SAVE runs (mem_we=1); a start pulse during busy is ignored; spurious mem_ack with mem_req=0 has no effect.
- Assert rst low during RESTORE after 5 words -> all outputs 0 immediately; r6..r15 unchanged; the next start_restore runs a full 15 words.
- base=16'hFFFA SAVE -> addresses wrap to 0x0000..0x0008 after 0xFFFF.
